// File: rtl/reg_access_arbiter_if.sv
// reg_access_arbiter_if: requester handshakes and storage-register strobes for reg_access_arbiter
interface reg_access_arbiter_if #(parameter int DATA_W = 16);
  logic r0_req, r0_we, r0_gnt, r0_rvalid;
  logic r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [DATA_W-1:0] r0_wdata, r1_wdata, rdata, reg_wdata, reg_rdata;
  logic busy, reg_read, reg_write;
  modport master (
    output r0_req, r0_we, r0_wdata, r1_req, r1_we, r1_wdata, reg_rdata,
    input r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata, busy, reg_read, reg_write, reg_wdata
  );
  modport slave (
    input r0_req, r0_we, r0_wdata, r1_req, r1_we, r1_wdata, reg_rdata,
    output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata, busy, reg_read, reg_write, reg_wdata
  );
endinterface

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: shares the result register between ALU writeback (r0) and load/store (r1)
module reg_access_arbiter #(
  parameter int DATA_W = 16,
  parameter int PRIORITY_MODE = 0
) (
  input logic clk,
  input logic rst_n,
  reg_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;
  state_t state, nstate;
  logic any, take, pick, n_we, win, we_q, last;
  logic [1:0] gnt, rvalid, n_gnt, n_rvalid;
  logic [DATA_W-1:0] wsel;
  assign any = bus.r0_req | bus.r1_req;
  assign take = (state == IDLE) && any;
  // pick = 1 selects r1; last resets to 1 so r0 wins the first tie
  assign pick = (PRIORITY_MODE == 1) ? ~bus.r0_req : ((bus.r0_req & bus.r1_req) ? ~last : bus.r1_req);
  assign n_we = pick ? bus.r1_we : bus.r0_we;
  assign wsel = pick ? bus.r1_wdata : bus.r0_wdata;
  assign bus.r0_gnt = gnt[0];
  assign bus.r1_gnt = gnt[1];
  assign bus.r0_rvalid = rvalid[0];
  assign bus.r1_rvalid = rvalid[1];
  always_comb begin
    nstate = state;
    n_gnt = 2'b00;
    n_rvalid = 2'b00;
    case (state)
      IDLE: if (any) begin
        nstate = ISSUE;
        n_gnt = pick ? 2'b10 : 2'b01;
      end
      ISSUE: nstate = we_q ? IDLE : RDATA;
      RDATA: begin
        nstate = IDLE;
        n_rvalid = win ? 2'b10 : 2'b01;
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      gnt <= 2'b00;
      rvalid <= 2'b00;
      win <= 1'b0;
      we_q <= 1'b0;
      last <= 1'b1;
      bus.busy <= 1'b0;
      bus.reg_read <= 1'b0;
      bus.reg_write <= 1'b0;
      bus.reg_wdata <= '0;
      bus.rdata <= '0;
    end else begin
      state <= nstate;
      gnt <= n_gnt;
      rvalid <= n_rvalid;
      bus.busy <= nstate != IDLE;
      bus.reg_write <= take & n_we;
      bus.reg_read <= take & ~n_we;
      if (take) begin
        win <= pick;
        we_q <= n_we;
        last <= pick;
        bus.reg_wdata <= wsel;
      end
      if (state == RDATA) bus.rdata <= bus.reg_rdata;
    end
endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb_reg_access_arbiter: directed checks of round-robin (u0) and fixed-priority (u1) arbiters
module tb_reg_access_arbiter;
  logic clk, rst_n, mon;
  logic [15:0] m0, m1;
  int checks, errors;
  reg_access_arbiter_if #(.DATA_W(16)) b0 ();
  reg_access_arbiter_if #(.DATA_W(16)) b1 ();
  reg_access_arbiter #(.DATA_W(16), .PRIORITY_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  reg_access_arbiter #(.DATA_W(16), .PRIORITY_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // storage register: write at the strobed edge, readResult updates at the edge reg_read is sampled
  always @(posedge clk) begin
    if (b0.reg_write) m0 <= b0.reg_wdata;
    if (b0.reg_read) b0.reg_rdata <= m0;
    if (b1.reg_write) m1 <= b1.reg_wdata;
    if (b1.reg_read) b1.reg_rdata <= m1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (mon) begin
      check("excl0", {b0.reg_read & b0.reg_write, b0.r0_gnt & b0.r1_gnt, b0.r0_rvalid & b0.r1_rvalid}, 0);
      check("excl1", {b1.reg_read & b1.reg_write, b1.r0_gnt & b1.r1_gnt, b1.r0_rvalid & b1.r1_rvalid}, 0);
    end
  initial begin
    checks = 0;
    errors = 0;
    mon = 1'b0;
    rst_n = 1'b0;
    b0.r0_req = 1'b1; b0.r0_we = 1'b1; b0.r0_wdata = 16'hA5C3;
    b0.r1_req = 1'b0; b0.r1_we = 1'b0; b0.r1_wdata = 16'h0000;
    b1.r0_req = 1'b0; b1.r0_we = 1'b0; b1.r0_wdata = 16'h0000;
    b1.r1_req = 1'b0; b1.r1_we = 1'b0; b1.r1_wdata = 16'h0000;
    tick;
    tick;
    check("rst_out", {b0.r0_gnt, b0.r1_gnt, b0.r0_rvalid, b0.r1_rvalid, b0.busy, b0.reg_read, b0.reg_write}, 0);
    check("rst_rdata", b0.rdata, 0);
    check("rst_wdata", b0.reg_wdata, 0);
    check("rst_out1", {b1.r0_gnt, b1.r1_gnt, b1.busy, b1.reg_read, b1.reg_write}, 0);
    mon = 1'b1;
    rst_n = 1'b1;
    tick;
    check("wr_gnt", {b0.r1_gnt, b0.r0_gnt}, 2'b01);
    check("wr_strobe", {b0.reg_read, b0.reg_write}, 2'b01);
    check("wr_data", b0.reg_wdata, 16'hA5C3);
    check("wr_busy", b0.busy, 1);
    b0.r0_req = 1'b0;
    b0.r1_req = 1'b1; b0.r1_we = 1'b0;
    tick;
    check("wr_done", {b0.busy, b0.r1_gnt, b0.r0_gnt, b0.reg_write}, 0);
    tick;
    check("rd_gnt", {b0.r1_gnt, b0.r0_gnt}, 2'b10);
    check("rd_strobe", {b0.reg_read, b0.reg_write}, 2'b10);
    b0.r1_req = 1'b0;
    tick;
    check("rd_wait", {b0.busy, b0.r1_rvalid, b0.r0_rvalid}, 3'b100);
    tick;
    check("rd_valid", {b0.r1_rvalid, b0.r0_rvalid}, 2'b10);
    check("rd_data", b0.rdata, 16'hA5C3);
    check("rd_idle", b0.busy, 0);
    tick;
    check("rd_pulse", {b0.r1_rvalid, b0.r0_rvalid}, 0);
    check("rd_hold", b0.rdata, 16'hA5C3);
    b0.r0_req = 1'b1; b0.r0_we = 1'b1; b0.r0_wdata = 16'h1111;
    b0.r1_req = 1'b1; b0.r1_we = 1'b1; b0.r1_wdata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rr_gnt", {b0.r1_gnt, b0.r0_gnt}, (i % 2) ? 2'b10 : 2'b01);
      check("rr_wdata", b0.reg_wdata, (i % 2) ? 16'h2222 : 16'h1111);
      tick;
      check("rr_gap", {b0.r1_gnt, b0.r0_gnt}, 0);
    end
    b0.r0_req = 1'b0;
    b0.r1_req = 1'b0;
    tick;
    check("rr_end", {b0.busy, b0.r1_gnt, b0.r0_gnt}, 0);
    b0.r1_req = 1'b1;
    #3;
    b0.r1_req = 1'b0;
    tick;
    check("wd_none", {b0.busy, b0.r1_gnt, b0.r0_gnt}, 0);
    b0.r0_req = 1'b1; b0.r0_we = 1'b0;
    tick;
    check("mr_gnt", {b0.r1_gnt, b0.r0_gnt}, 2'b01);
    b0.r0_req = 1'b0;
    tick;
    check("mr_busy", b0.busy, 1);
    rst_n = 1'b0;
    tick;
    check("mr_novalid", {b0.r1_rvalid, b0.r0_rvalid}, 0);
    check("mr_rdata", b0.rdata, 0);
    check("mr_idle", b0.busy, 0);
    rst_n = 1'b1;
    tick;
    check("mr_after", {b0.r1_rvalid, b0.r0_rvalid, b0.busy}, 0);
    b0.r0_req = 1'b1; b0.r0_we = 1'b1; b0.r0_wdata = 16'h1234;
    b0.r1_req = 1'b1; b0.r1_we = 1'b0;
    tick;
    check("raw_wgnt", {b0.r1_gnt, b0.r0_gnt}, 2'b01);
    check("raw_wstrobe", {b0.reg_read, b0.reg_write}, 2'b01);
    b0.r0_req = 1'b0;
    tick;
    tick;
    check("raw_rgnt", {b0.r1_gnt, b0.r0_gnt}, 2'b10);
    check("raw_rstrobe", {b0.reg_read, b0.reg_write}, 2'b10);
    b0.r1_req = 1'b0;
    tick;
    tick;
    check("raw_valid", {b0.r1_rvalid, b0.r0_rvalid}, 2'b10);
    check("raw_data", b0.rdata, 16'h1234);
    tick;
    check("raw_pulse", {b0.r1_rvalid, b0.r0_rvalid}, 0);
    b1.r0_req = 1'b1; b1.r0_we = 1'b1; b1.r0_wdata = 16'h00AA;
    b1.r1_req = 1'b1; b1.r1_we = 1'b1; b1.r1_wdata = 16'h00BB;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("fp_gnt", {b1.r1_gnt, b1.r0_gnt}, 2'b01);
      tick;
      check("fp_gap", {b1.r1_gnt, b1.r0_gnt}, 0);
    end
    b1.r0_req = 1'b0;
    tick;
    check("fp_r1", {b1.r1_gnt, b1.r0_gnt}, 2'b10);
    check("fp_wdata", b1.reg_wdata, 16'h00BB);
    b1.r1_req = 1'b0;
    tick;
    check("fp_idle", {b1.busy, b1.r1_gnt, b1.r0_gnt}, 0);
    mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
